// File: rtl/station_pkg.sv
// Shared constants, ramp state encoding and width helper for the station arm blocks.
package station_pkg;

  localparam int unsigned WIDTH_W = 12;
  typedef logic [WIDTH_W-1:0] width_t;

  // Servo command encoding from the material system
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  // Default timing values (microseconds unless noted)
  localparam int unsigned DEF_CLK_HZ        = 100_000_000;
  localparam int unsigned DEF_PERIOD_US     = 20000;
  localparam int unsigned DEF_UP_US         = 1000;
  localparam int unsigned DEF_DOWN_US       = 2000;
  localparam int unsigned DEF_STEP_US       = 50;
  localparam int unsigned DEF_SETTLE_FRAMES = 10;

  // Move cur toward tgt by at most step; differences are compared before the
  // add/subtract so the result can never wrap or overshoot the target.
  function automatic width_t step_toward(input width_t cur, input width_t tgt, input width_t step);
    width_t res;
    if (cur < tgt) begin
      res = ((tgt - cur) > step) ? width_t'(cur + step) : tgt;
    end else begin
      res = ((cur - tgt) > step) ? width_t'(cur - step) : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_HZ/1e6 clocks. Tick is
// combinational from the counter so consumers see it in the wrap cycle.
module us_tick_gen
  import station_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_c_o
);

  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap detect and next count
  always_comb begin
    tick_c_o = (cnt_q == LAST);
    cnt_d    = tick_c_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Prescaler register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// 50 Hz hobby-servo PWM driver with frame-by-frame slewing between the UP and
// DOWN widths and a settled flag. Build option SERVO_RAMP_EN: when defined the
// width slews by STEP_US per frame; otherwise it jumps to the target in one frame.
module servo_pwm_driver
  import station_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
  parameter int unsigned PERIOD_US     = DEF_PERIOD_US,
  parameter int unsigned UP_US         = DEF_UP_US,
  parameter int unsigned DOWN_US       = DEF_DOWN_US,
  parameter int unsigned STEP_US       = DEF_STEP_US,
  parameter int unsigned SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               controlServo,
  output logic               servoPWM,
  output logic               servoSettled,
  output logic [WIDTH_W-1:0] pulseWidth
);

  localparam int unsigned FRAME_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam int unsigned SPAN_US  = DOWN_US - UP_US;
  localparam width_t UP_W   = width_t'(UP_US);
  localparam width_t DOWN_W = width_t'(DOWN_US);
`ifdef SERVO_RAMP_EN
  localparam width_t STEP_W = width_t'(STEP_US);
`else
  // A step at least as large as the full swing lands on the target in one frame
  localparam width_t STEP_W = width_t'((STEP_US > SPAN_US) ? STEP_US : SPAN_US);
`endif
  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(PERIOD_US - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_FRAMES);

  logic                us_tick_c;
  logic                frame_start_c;
  width_t              tgt_us_c;

  logic                sync1_q, tgt_sync_q;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  width_t              pulse_width_q, pulse_width_d;
  ramp_state_e         state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                frame_seen_q, frame_seen_d;
  logic                servo_pwm_q, servo_pwm_d;
  logic                settled_q, settled_d;

  us_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_us_tick (
    .clk_i    (CLK),
    .rst_i    (RST),
    .tick_c_o (us_tick_c)
  );

  // Frame timing, target selection, ramp FSM next state and output compare
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    pulse_width_d = pulse_width_q;
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;

    frame_start_c = us_tick_c && (frame_cnt_q == '0);
    tgt_us_c      = (tgt_sync_q == DOWN) ? DOWN_W : UP_W;
    // The strobe right after reset opens the first frame rather than closing one
    frame_seen_d  = frame_seen_q | frame_start_c;

    if (us_tick_c) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FRAME_W'(1);
    end

    if (frame_start_c) begin
      case (state_q)
        HOLD: begin
          if (pulse_width_q == tgt_us_c) begin
            if (frame_seen_q && (settle_cnt_q != SETTLE_MAX)) begin
              settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
          end else begin
            settle_cnt_d = '0;
            state_d      = RAMP;
          end
        end
        RAMP: begin
          pulse_width_d = step_toward(pulse_width_q, tgt_us_c, STEP_W);
          if (pulse_width_d == tgt_us_c) begin
            state_d      = HOLD;
            settle_cnt_d = '0;
          end
        end
        default: state_d = HOLD;
      endcase
    end

    servo_pwm_d = (32'(frame_cnt_q) < 32'(pulse_width_q));
    settled_d   = (state_d == HOLD) && (settle_cnt_d == SETTLE_MAX);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q       <= UP;
      tgt_sync_q    <= UP;
      frame_cnt_q   <= '0;
      pulse_width_q <= UP_W;
      state_q       <= HOLD;
      settle_cnt_q  <= '0;
      frame_seen_q  <= 1'b0;
      servo_pwm_q   <= 1'b0;
      settled_q     <= 1'b0;
    end else begin
      sync1_q       <= controlServo;
      tgt_sync_q    <= sync1_q;
      frame_cnt_q   <= frame_cnt_d;
      pulse_width_q <= pulse_width_d;
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      frame_seen_q  <= frame_seen_d;
      servo_pwm_q   <= servo_pwm_d;
      settled_q     <= settled_d;
    end
  end

  assign servoPWM     = servo_pwm_q;
  assign servoSettled = settled_q;
  assign pulseWidth   = pulse_width_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed frame-by-frame bench for servo_pwm_driver using a 1 MHz clock so
// one cycle equals one microsecond and a frame is 100 cycles.
module tb_servo_pwm_driver;

  localparam int unsigned PERIOD = 100;
  localparam int          NVEC   = 17;

  typedef struct {
    logic        ctrl;     // command level applied mid-frame
    logic        glitch;   // pulse the command high for 10 cycles first
    int unsigned width;    // expected width for this frame
    logic        settled;  // expected settled flag at frame start
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        controlServo;
  logic        servoPWM;
  logic        servoSettled;
  logic [11:0] pulseWidth;

  vec_t vecs [NVEC];
  int   n_checks;
  int   n_errors;

  servo_pwm_driver #(
    .CLK_HZ        (1_000_000),
    .PERIOD_US     (100),
    .UP_US         (10),
    .DOWN_US       (30),
    .STEP_US       (5),
    .SETTLE_FRAMES (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .controlServo (controlServo),
    .servoPWM     (servoPWM),
    .servoSettled (servoSettled),
    .pulseWidth   (pulseWidth)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int f, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s frame %0d: got %0d expected %0d", name, f, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic c, input logic g, input int unsigned w, input logic s);
    vecs[idx] = '{ctrl: c, glitch: g, width: w, settled: s};
  endtask

  // One full frame: check width/settled at its start, count the high cycles
  task automatic run_frame(input int f, input logic c, input logic g, input int unsigned w, input logic s);
    int unsigned highs;
    highs = 0;
    for (int k = 0; k < int'(PERIOD); k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (servoPWM) highs++;
      if (k == 0) begin
        check("width", f, 32'(pulseWidth), w);
        check("settled", f, 32'(servoSettled), 32'(s));
      end
      if (k == int'(w)) check("pwm_fall", f, 32'(servoPWM), 0);
      if (g && k == 40) controlServo = 1'b1;
      if (k == 50) controlServo = c;
    end
    check("pwm_high", f, highs, w);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

`ifdef SERVO_RAMP_EN
    set_vec(0,  1'b0, 1'b0, 10, 1'b0);
    set_vec(1,  1'b0, 1'b0, 10, 1'b0);
    set_vec(2,  1'b0, 1'b0, 10, 1'b1);
    set_vec(3,  1'b0, 1'b1, 10, 1'b1);
    set_vec(4,  1'b1, 1'b0, 10, 1'b1);
    set_vec(5,  1'b1, 1'b0, 10, 1'b0);
    set_vec(6,  1'b1, 1'b0, 15, 1'b0);
    set_vec(7,  1'b0, 1'b0, 20, 1'b0);
    set_vec(8,  1'b0, 1'b0, 15, 1'b0);
    set_vec(9,  1'b1, 1'b0, 10, 1'b0);
    set_vec(10, 1'b1, 1'b0, 10, 1'b0);
    set_vec(11, 1'b1, 1'b0, 15, 1'b0);
    set_vec(12, 1'b1, 1'b0, 20, 1'b0);
    set_vec(13, 1'b1, 1'b0, 25, 1'b0);
    set_vec(14, 1'b1, 1'b0, 30, 1'b0);
    set_vec(15, 1'b1, 1'b0, 30, 1'b0);
    set_vec(16, 1'b1, 1'b0, 30, 1'b1);
`else
    set_vec(0,  1'b0, 1'b0, 10, 1'b0);
    set_vec(1,  1'b0, 1'b0, 10, 1'b0);
    set_vec(2,  1'b0, 1'b0, 10, 1'b1);
    set_vec(3,  1'b0, 1'b1, 10, 1'b1);
    set_vec(4,  1'b1, 1'b0, 10, 1'b1);
    set_vec(5,  1'b1, 1'b0, 10, 1'b0);
    set_vec(6,  1'b1, 1'b0, 30, 1'b0);
    set_vec(7,  1'b1, 1'b0, 30, 1'b0);
    set_vec(8,  1'b0, 1'b0, 30, 1'b1);
    set_vec(9,  1'b0, 1'b0, 30, 1'b0);
    set_vec(10, 1'b0, 1'b0, 10, 1'b0);
    set_vec(11, 1'b0, 1'b0, 10, 1'b0);
    set_vec(12, 1'b1, 1'b0, 10, 1'b1);
    set_vec(13, 1'b1, 1'b0, 10, 1'b0);
    set_vec(14, 1'b1, 1'b0, 30, 1'b0);
    set_vec(15, 1'b1, 1'b0, 30, 1'b0);
    set_vec(16, 1'b1, 1'b0, 30, 1'b1);
`endif

    RST          = 1'b1;
    controlServo = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_pwm", -1, 32'(servoPWM), 0);
    check("rst_settled", -1, 32'(servoSettled), 0);
    check("rst_width", -1, 32'(pulseWidth), 10);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_frame(i, vecs[i].ctrl, vecs[i].glitch, vecs[i].width, vecs[i].settled);
    end

    // Reset in the middle of a high pulse at frame count 5
    repeat (6) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("pre_rst_pwm", NVEC, 32'(servoPWM), 1);
    check("pre_rst_width", NVEC, 32'(pulseWidth), 30);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_pwm", NVEC, 32'(servoPWM), 0);
    check("midrst_width", NVEC, 32'(pulseWidth), 10);
    check("midrst_settled", NVEC, 32'(servoSettled), 0);
    RST          = 1'b0;
    controlServo = 1'b0;
    run_frame(NVEC + 1, 1'b0, 1'b0, 10, 1'b0);
    run_frame(NVEC + 2, 1'b0, 1'b0, 10, 1'b0);
    run_frame(NVEC + 3, 1'b0, 1'b0, 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
